// File: rtl/ddr_arb_pkg.sv
// rtl/ddr_arb_pkg.sv - shared widths, enums and grant bit positions for the DDR arbiter
//
// Purpose: common types for ddr_arbiter and its priority picker.
// Ports:   none (package).
package ddr_arb_pkg;

  localparam int DDR_INDEX_W = 19;
  localparam int DDR_DATA_W  = 64;
  localparam int DDR_BURST_W = 512;

  typedef enum logic {
    ARB_IDLE,
    ARB_WAIT
  } arb_state_e;

  typedef enum logic [1:0] {
    CH_NONE,
    CH_STORE,
    CH_LOAD,
    CH_PC
  } arb_chan_e;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_STORE = 0;
  localparam int GNT_LOAD  = 1;
  localparam int GNT_PC    = 2;

endpackage

// File: rtl/ddr_arb_prio_sel.sv
// rtl/ddr_arb_prio_sel.sv - combinational channel picker for the DDR arbiter
//
// Purpose: picks one requesting channel. Normal order is store > load > pc;
//          with pc_force_i set the order becomes pc > store > load.
// Ports:   store_valid_i, load_valid_i, pc_valid_i - request valids
//          pc_force_i                              - starvation override
//          grant_o                                 - one-hot grant (GNT_* bits)
//          chan_o                                  - granted channel, CH_NONE if idle
module ddr_arb_prio_sel
  import ddr_arb_pkg::*;
(
  input  logic       store_valid_i,
  input  logic       load_valid_i,
  input  logic       pc_valid_i,
  input  logic       pc_force_i,
  output logic [2:0] grant_o,
  output arb_chan_e  chan_o
);

  always_comb begin
    grant_o = '0;
    chan_o  = CH_NONE;
    if (pc_force_i && pc_valid_i) begin
      grant_o[GNT_PC] = 1'b1;
      chan_o          = CH_PC;
    end else if (store_valid_i) begin
      grant_o[GNT_STORE] = 1'b1;
      chan_o             = CH_STORE;
    end else if (load_valid_i) begin
      grant_o[GNT_LOAD] = 1'b1;
      chan_o            = CH_LOAD;
    end else if (pc_valid_i) begin
      grant_o[GNT_PC] = 1'b1;
      chan_o          = CH_PC;
    end
  end

endmodule

// File: rtl/ddr_arbiter.sv
// rtl/ddr_arbiter.sv - three-channel arbiter in front of the single-port simddr interface
//
// Purpose: accepts one fetch/load/store request at a time, issues it to DDR
//          as a one-cycle chip_enable pulse, waits for ddr_operation_done and
//          returns data plus a done pulse to the owning channel. A starvation
//          counter lifts fetch to top priority, a watchdog ends lost requests.
// Ports:   clock, reset                    - clock, synchronous active-high reset
//          pc_*                            - fetch burst channel (512-bit read)
//          opload_*                        - load channel (64-bit read)
//          opstore_*                       - store channel (64-bit mask + data)
//          ddr_chip_enable/index/write_enable/burst_mode/opstore_* - DDR issue side
//          ddr_opload_read_data, ddr_pc_read_inst, ddr_operation_done, ddr_ready - DDR return side
//          err_timeout                     - sticky watchdog flag
module ddr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset,

  input  logic                   pc_index_valid,
  input  logic [DDR_INDEX_W-1:0] pc_index,
  output logic                   pc_index_ready,
  output logic [DDR_BURST_W-1:0] pc_read_inst,
  output logic                   pc_operation_done,

  input  logic                   opload_index_valid,
  input  logic [DDR_INDEX_W-1:0] opload_index,
  output logic                   opload_index_ready,
  output logic [DDR_DATA_W-1:0]  opload_read_data,
  output logic                   opload_operation_done,

  input  logic                   opstore_index_valid,
  input  logic [DDR_INDEX_W-1:0] opstore_index,
  input  logic [DDR_DATA_W-1:0]  opstore_write_mask,
  input  logic [DDR_DATA_W-1:0]  opstore_write_data,
  output logic                   opstore_index_ready,
  output logic                   opstore_operation_done,

  output logic                   ddr_chip_enable,
  output logic [DDR_INDEX_W-1:0] ddr_index,
  output logic                   ddr_write_enable,
  output logic                   ddr_burst_mode,
  output logic [DDR_DATA_W-1:0]  ddr_opstore_write_mask,
  output logic [DDR_DATA_W-1:0]  ddr_opstore_write_data,
  input  logic [DDR_DATA_W-1:0]  ddr_opload_read_data,
  input  logic [DDR_BURST_W-1:0] ddr_pc_read_inst,
  input  logic                   ddr_operation_done,
  input  logic                   ddr_ready,

  output logic                   err_timeout
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_e             state_q, state_d;
  arb_chan_e              owner_q;
  logic [SC_W-1:0]        starve_q, starve_d;
  logic [WD_W-1:0]        wd_q, wd_d;

  logic                   issue_q;
  logic [DDR_INDEX_W-1:0] index_q;
  logic                   we_q;
  logic                   burst_q;
  logic [DDR_DATA_W-1:0]  mask_q;
  logic [DDR_DATA_W-1:0]  wdata_q;
  logic [DDR_BURST_W-1:0] pc_inst_q;
  logic [DDR_DATA_W-1:0]  ld_data_q;
  logic                   pc_done_q;
  logic                   ld_done_q;
  logic                   st_done_q;
  logic                   err_q;

  logic [2:0]             grant;
  arb_chan_e              sel_chan;
  logic                   pc_force;
  logic                   grant_ok;
  logic                   accept;
  logic                   finish;
  logic                   timeout_hit;
  logic [DDR_INDEX_W-1:0] sel_index;

  assign pc_force = (starve_q == STARVE_MAX);

  ddr_arb_prio_sel u_prio_sel (
    .store_valid_i (opstore_index_valid),
    .load_valid_i  (opload_index_valid),
    .pc_valid_i    (pc_index_valid),
    .pc_force_i    (pc_force),
    .grant_o       (grant),
    .chan_o        (sel_chan)
  );

  assign grant_ok = (state_q == ARB_IDLE) && ddr_ready;
  assign accept   = grant_ok && (|grant);

  // A real done wins over a watchdog expiry landing in the same cycle.
  assign finish      = (state_q == ARB_WAIT) && (ddr_operation_done || (wd_q == WD_LAST));
  assign timeout_hit = (state_q == ARB_WAIT) && !ddr_operation_done && (wd_q == WD_LAST);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (accept) state_d = ARB_WAIT;
      ARB_WAIT: if (finish) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Output logic: grants are combinational so valid && ready completes the handshake in-cycle.
  always_comb begin
    opstore_index_ready = 1'b0;
    opload_index_ready  = 1'b0;
    pc_index_ready      = 1'b0;
    if (grant_ok) begin
      opstore_index_ready = grant[GNT_STORE];
      opload_index_ready  = grant[GNT_LOAD];
      pc_index_ready      = grant[GNT_PC];
    end
  end

  always_comb begin
    sel_index = pc_index;
    if (grant[GNT_STORE]) begin
      sel_index = opstore_index;
    end else if (grant[GNT_LOAD]) begin
      sel_index = opload_index;
    end
  end

  // The starvation count only means something while fetch is actually waiting.
  always_comb begin
    starve_d = starve_q;
    if (!pc_index_valid || (accept && grant[GNT_PC])) begin
      starve_d = '0;
    end else if (accept && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    wd_d = '0;
    if ((state_q == ARB_WAIT) && !finish) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q   <= CH_NONE;
      starve_q  <= '0;
      wd_q      <= '0;
      issue_q   <= 1'b0;
      index_q   <= '0;
      we_q      <= 1'b0;
      burst_q   <= 1'b0;
      mask_q    <= '0;
      wdata_q   <= '0;
      pc_inst_q <= '0;
      ld_data_q <= '0;
      pc_done_q <= 1'b0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      wd_q      <= wd_d;
      issue_q   <= accept;
      pc_done_q <= finish && (owner_q == CH_PC);
      ld_done_q <= finish && (owner_q == CH_LOAD);
      st_done_q <= finish && (owner_q == CH_STORE);

      if (accept) begin
        owner_q <= sel_chan;
        index_q <= sel_index;
        we_q    <= grant[GNT_STORE];
        burst_q <= grant[GNT_PC];
        mask_q  <= grant[GNT_STORE] ? opstore_write_mask : '0;
        wdata_q <= grant[GNT_STORE] ? opstore_write_data : '0;
      end else if (finish) begin
        owner_q <= CH_NONE;
        index_q <= '0;
        we_q    <= 1'b0;
        burst_q <= 1'b0;
        mask_q  <= '0;
        wdata_q <= '0;
      end

      // Read data is only captured on a genuine completion, never on a watchdog expiry.
      if (finish && ddr_operation_done && (owner_q == CH_PC)) begin
        pc_inst_q <= ddr_pc_read_inst;
      end
      if (finish && ddr_operation_done && (owner_q == CH_LOAD)) begin
        ld_data_q <= ddr_opload_read_data;
      end

      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ddr_chip_enable        = issue_q;
  assign ddr_index              = index_q;
  assign ddr_write_enable       = we_q;
  assign ddr_burst_mode         = burst_q;
  assign ddr_opstore_write_mask = mask_q;
  assign ddr_opstore_write_data = wdata_q;
  assign pc_read_inst           = pc_inst_q;
  assign opload_read_data       = ld_data_q;
  assign pc_operation_done      = pc_done_q;
  assign opload_operation_done  = ld_done_q;
  assign opstore_operation_done = st_done_q;
  assign err_timeout            = err_q;

endmodule

// File: tb/tb_ddr_arbiter.sv
// tb/tb_ddr_arbiter.sv - scoreboard testbench for ddr_arbiter
module tb_ddr_arbiter;

  localparam int STARVE = 4;
  localparam int TMO    = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         pc_index_valid, opload_index_valid, opstore_index_valid;
  logic [18:0]  pc_index, opload_index, opstore_index;
  logic [63:0]  opstore_write_mask, opstore_write_data;
  logic         pc_index_ready, opload_index_ready, opstore_index_ready;
  logic [511:0] pc_read_inst;
  logic [63:0]  opload_read_data;
  logic         pc_operation_done, opload_operation_done, opstore_operation_done;
  logic         ddr_chip_enable, ddr_write_enable, ddr_burst_mode;
  logic [18:0]  ddr_index;
  logic [63:0]  ddr_opstore_write_mask, ddr_opstore_write_data;
  logic [63:0]  ddr_opload_read_data;
  logic [511:0] ddr_pc_read_inst;
  logic         ddr_operation_done;
  logic         ddr_ready;
  logic         err_timeout;

  always #5 clock = ~clock;

  ddr_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT_CYCLES(TMO)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .pc_index_valid         (pc_index_valid),
    .pc_index               (pc_index),
    .pc_index_ready         (pc_index_ready),
    .pc_read_inst           (pc_read_inst),
    .pc_operation_done      (pc_operation_done),
    .opload_index_valid     (opload_index_valid),
    .opload_index           (opload_index),
    .opload_index_ready     (opload_index_ready),
    .opload_read_data       (opload_read_data),
    .opload_operation_done  (opload_operation_done),
    .opstore_index_valid    (opstore_index_valid),
    .opstore_index          (opstore_index),
    .opstore_write_mask     (opstore_write_mask),
    .opstore_write_data     (opstore_write_data),
    .opstore_index_ready    (opstore_index_ready),
    .opstore_operation_done (opstore_operation_done),
    .ddr_chip_enable        (ddr_chip_enable),
    .ddr_index              (ddr_index),
    .ddr_write_enable       (ddr_write_enable),
    .ddr_burst_mode         (ddr_burst_mode),
    .ddr_opstore_write_mask (ddr_opstore_write_mask),
    .ddr_opstore_write_data (ddr_opstore_write_data),
    .ddr_opload_read_data   (ddr_opload_read_data),
    .ddr_pc_read_inst       (ddr_pc_read_inst),
    .ddr_operation_done     (ddr_operation_done),
    .ddr_ready              (ddr_ready),
    .err_timeout            (err_timeout)
  );

  typedef struct {
    logic [18:0] idx;
    logic        we;
    logic        burst;
    logic [63:0] mask;
    logic [63:0] data;
  } iss_t;

  typedef struct {
    int           ch;    // 0 store, 1 load, 2 pc
    logic [511:0] data;
    int           gap;   // cycles from chip_enable to done pulse
    logic         err;
  } done_t;

  iss_t         iss_q[$];
  done_t        done_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           ce_cyc = 0;
  int           done_seen = 0;
  logic [511:0] resp_pc = '0;
  logic [63:0]  resp_ld = '0;
  int           lat = 3;
  bit           mute = 0;
  bit           stray = 0;
  int           pend = 0;
  bit           st_sticky = 0;
  bit           ld_sticky = 0;

  assign ddr_opload_read_data = resp_ld;
  assign ddr_pc_read_inst     = resp_pc;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_issue(input logic [18:0] idx, input logic we, input logic burst,
                           input logic [63:0] mask, input logic [63:0] data);
    iss_t e;
    e.idx = idx; e.we = we; e.burst = burst; e.mask = mask; e.data = data;
    iss_q.push_back(e);
  endtask

  task automatic exp_done(input int ch, input logic [511:0] data, input int gap, input logic err);
    done_t e;
    e.ch = ch; e.data = data; e.gap = gap; e.err = err;
    done_q.push_back(e);
  endtask

  // DDR model: done arrives `lat` cycles after the chip_enable cycle.
  initial begin
    ddr_operation_done = 1'b0;
    forever begin
      @(negedge clock);
      ddr_operation_done = stray;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && !mute) ddr_operation_done = 1'b1;
      end
      if (ddr_chip_enable) pend = lat;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT issues or completes.
  initial begin
    iss_t  ei;
    done_t ed;
    int    n, ach;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (ddr_chip_enable) begin
          ce_cyc = cyc;
          if (iss_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_issue: got index %0h expected no issue", ddr_index);
          end else begin
            ei = iss_q.pop_front();
            chk("issue_index", ddr_index, ei.idx);
            chk("issue_we", ddr_write_enable, ei.we);
            chk("issue_burst", ddr_burst_mode, ei.burst);
            chk("issue_mask", ddr_opstore_write_mask, ei.mask);
            chk("issue_data", ddr_opstore_write_data, ei.data);
          end
        end
        n = int'(pc_operation_done) + int'(opload_operation_done) + int'(opstore_operation_done);
        if (n != 0) begin
          done_seen++;
          if (done_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got %0d pulses expected none", n);
          end else begin
            ed = done_q.pop_front();
            ach = pc_operation_done ? 2 : (opload_operation_done ? 1 : 0);
            chk("done_onehot", n, 1);
            chk("done_channel", ach, ed.ch);
            chk("done_gap", cyc - ce_cyc, ed.gap);
            chk("done_err", err_timeout, ed.err);
            if (ed.ch == 2) chk("done_pc_data", pc_read_inst, ed.data);
            if (ed.ch == 1) chk("done_load_data", opload_read_data, ed.data);
          end
        end
      end
    end
  end

  // Holds requests until accepted; a pc acceptance ends the burst of requests.
  task automatic drive(input int budget);
    bit st_a, ld_a, pc_a;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      chk("ready_onehot", (int'(pc_index_ready) + int'(opload_index_ready) + int'(opstore_index_ready)) <= 1, 1);
      st_a = opstore_index_valid && opstore_index_ready;
      ld_a = opload_index_valid && opload_index_ready;
      pc_a = pc_index_valid && pc_index_ready;
      @(posedge clock); #1;
      if (pc_a) begin
        pc_index_valid = 0; opload_index_valid = 0; opstore_index_valid = 0;
      end
      if (st_a && !st_sticky) opstore_index_valid = 0;
      if (ld_a && !ld_sticky) opload_index_valid = 0;
      if (!(pc_index_valid || opload_index_valid || opstore_index_valid)) return;
    end
    chk("drive_budget", pc_index_valid || opload_index_valid || opstore_index_valid, 0);
    pc_index_valid = 0; opload_index_valid = 0; opstore_index_valid = 0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clock); #1;
      if (iss_q.size() == 0 && done_q.size() == 0) break;
    end
    chk("drain_issue_queue", iss_q.size(), 0);
    chk("drain_done_queue", done_q.size(), 0);
    iss_q.delete();
    done_q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ce"}, ddr_chip_enable, 0);
    chk({tag, "_index"}, ddr_index, 0);
    chk({tag, "_we_burst"}, {ddr_write_enable, ddr_burst_mode}, 0);
    chk({tag, "_mask_data"}, {ddr_opstore_write_mask, ddr_opstore_write_data}, 0);
    chk({tag, "_pc_inst"}, pc_read_inst, 0);
    chk({tag, "_load_data"}, opload_read_data, 0);
    chk({tag, "_done"}, {pc_operation_done, opload_operation_done, opstore_operation_done}, 0);
    chk({tag, "_ready"}, {pc_index_ready, opload_index_ready, opstore_index_ready}, 0);
    chk({tag, "_err"}, err_timeout, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int snap;
    pc_index_valid = 0; opload_index_valid = 0; opstore_index_valid = 0;
    pc_index = '0; opload_index = '0; opstore_index = '0;
    opstore_write_mask = '0; opstore_write_data = '0;
    ddr_ready = 1;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    @(posedge clock); #1;
    reset = 0;
    @(posedge clock); #1;

    // Single load, DDR latency 3
    resp_ld = 64'hDEAD_BEEF; lat = 3;
    exp_issue(19'h00010, 0, 0, 64'h0, 64'h0);
    exp_done(1, 512'hDEAD_BEEF, 4, 0);
    opload_index = 19'h00010; opload_index_valid = 1;
    @(negedge clock);
    chk("t1_ready_at_T", opload_index_ready, 1);
    chk("t1_no_ce_at_T", ddr_chip_enable, 0);
    @(posedge clock); #1;
    opload_index_valid = 0;
    @(negedge clock);
    chk("t1_ce_at_T1", ddr_chip_enable, 1);
    drain(20);
    repeat (3) @(negedge clock);
    chk("t1_load_held", opload_read_data, 64'hDEAD_BEEF);
    @(posedge clock); #1;

    // All three valid together: store, then load, then pc
    for (int i = 0; i < 8; i++) resp_pc[i*64 +: 64] = {32'hA5A5_5A5A, 32'(i + 1)};
    resp_ld = 64'hCAFE_F00D_1234_5678;
    exp_issue(19'd100, 1, 0, 64'hFF00_FF00_FF00_FF00, 64'h0123_4567_89AB_CDEF);
    exp_issue(19'd200, 0, 0, 64'h0, 64'h0);
    exp_issue(19'd300, 0, 1, 64'h0, 64'h0);
    exp_done(0, 512'h0, 4, 0);
    exp_done(1, 512'hCAFE_F00D_1234_5678, 4, 0);
    exp_done(2, resp_pc, 4, 0);
    opstore_index = 19'd100; opstore_write_mask = 64'hFF00_FF00_FF00_FF00;
    opstore_write_data = 64'h0123_4567_89AB_CDEF; opstore_index_valid = 1;
    opload_index = 19'd200; opload_index_valid = 1;
    pc_index = 19'd300; pc_index_valid = 1;
    drive(60);
    drain(40);

    // Starvation: pc forced after exactly STARVE data grants
    lat = 1;
    resp_pc = ~resp_pc;
    st_sticky = 1; ld_sticky = 1;
    for (int i = 0; i < STARVE; i++) begin
      exp_issue(19'h7, 1, 0, 64'hFFFF, 64'h5555);
      exp_done(0, 512'h0, 2, 0);
    end
    exp_issue(19'h9, 0, 1, 64'h0, 64'h0);
    exp_done(2, resp_pc, 2, 0);
    opstore_index = 19'h7; opstore_write_mask = 64'hFFFF; opstore_write_data = 64'h5555;
    opload_index = 19'h8; pc_index = 19'h9;
    opstore_index_valid = 1; opload_index_valid = 1; pc_index_valid = 1;
    drive(80);
    drain(20);
    st_sticky = 0; ld_sticky = 0;

    // Counter cleared: store wins again over pc
    exp_issue(19'h7, 1, 0, 64'hFFFF, 64'h5555);
    exp_issue(19'h9, 0, 1, 64'h0, 64'h0);
    exp_done(0, 512'h0, 2, 0);
    exp_done(2, resp_pc, 2, 0);
    opstore_index_valid = 1; pc_index_valid = 1;
    drive(30);
    drain(20);

    // ddr_ready low for 5 cycles
    lat = 3;
    resp_ld = 64'h1111_2222_3333_4444;
    ddr_ready = 0;
    opload_index = 19'h20; opload_index_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t4_no_ready", opload_index_ready, 0);
      chk("t4_no_ce", ddr_chip_enable, 0);
      @(posedge clock); #1;
    end
    exp_issue(19'h20, 0, 0, 64'h0, 64'h0);
    exp_done(1, 512'h1111_2222_3333_4444, 4, 0);
    ddr_ready = 1;
    @(negedge clock);
    chk("t4_ready_first_cycle", opload_index_ready, 1);
    @(posedge clock); #1;
    opload_index_valid = 0;
    drain(20);

    // Watchdog: no done returned
    mute = 1;
    resp_ld = 64'h9999_9999_9999_9999;
    exp_issue(19'h30, 0, 0, 64'h0, 64'h0);
    exp_done(1, 512'h1111_2222_3333_4444, TMO, 1);
    opload_index = 19'h30; opload_index_valid = 1;
    drive(10);
    drain(40);
    chk("t5_err_set", err_timeout, 1);
    snap = done_seen;
    stray = 1;
    @(posedge clock); #1;
    stray = 0;
    repeat (4) @(posedge clock);
    #1;
    chk("t5_stray_no_pulse", done_seen, snap);
    chk("t5_err_sticky", err_timeout, 1);
    mute = 0;

    // Reset while waiting, then a late done
    lat = 3;
    resp_ld = 64'hABCD;
    exp_issue(19'h40, 0, 0, 64'h0, 64'h0);
    opload_index = 19'h40; opload_index_valid = 1;
    @(negedge clock);
    chk("t6_ready", opload_index_ready, 1);
    @(posedge clock); #1;
    opload_index_valid = 0;
    @(negedge clock);
    chk("t6_ce", ddr_chip_enable, 1);
    @(posedge clock); #1;
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    snap = done_seen;
    @(negedge clock);
    check_zero("t6_after_reset");
    repeat (5) @(posedge clock);
    #1;
    chk("t6_no_done", done_seen, snap);

    resp_ld = 64'h7777_8888;
    exp_issue(19'h50, 0, 0, 64'h0, 64'h0);
    exp_done(1, 512'h7777_8888, 4, 0);
    opload_index = 19'h50; opload_index_valid = 1;
    drive(10);
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_arbiter.md
Name: ddr_arbiter

Overview:
Three-channel arbiter between the core's memory requesters (instruction-fetch burst read, data load, data store) and the single-port simddr interface (chip_enable / index / burst / write mask+data / operation_done / ready). It accepts one request at a time and issues it to DDR as a one-cycle chip_enable pulse. It waits for ddr_operation_done, then returns read data and a done pulse to the owning channel. A starvation guard keeps fetch from being locked out by data traffic, and a watchdog stops a lost response from hanging the core.

Parameters:
STARVE_LIMIT, 4, consecutive non-pc grants while pc_index_valid is high before pc is forced to top priority (>=1)
TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before the watchdog fires (>=2)

Ports:
clock  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high
pc_index_valid  in  1  fetch burst request
pc_index  in  19  fetch index
pc_index_ready  out  1  fetch request granted this cycle
pc_read_inst  out  512  fetch burst data, held until the next pc completion
pc_operation_done  out  1  one-cycle fetch completion pulse
opload_index_valid  in  1  load request
opload_index  in  19  load index
opload_index_ready  out  1  load granted this cycle
opload_read_data  out  64  load data, held until the next load completion
opload_operation_done  out  1  one-cycle load completion pulse
opstore_index_valid  in  1  store request
opstore_index  in  19  store index
opstore_write_mask  in  64  store byte/bit mask
opstore_write_data  in  64  store data
opstore_index_ready  out  1  store granted this cycle
opstore_operation_done  out  1  one-cycle store completion pulse
ddr_chip_enable  out  1  one-cycle issue pulse
ddr_index  out  19  issued index
ddr_write_enable  out  1  1 = store
ddr_burst_mode  out  1  1 = pc burst read
ddr_opstore_write_mask  out  64  store mask, 0 when not storing
ddr_opstore_write_data  out  64  store data, 0 when not storing
ddr_opload_read_data  in  64  load data from DDR
ddr_pc_read_inst  in  512  burst data from DDR
ddr_operation_done  in  1  DDR completion
ddr_ready  in  1  DDR can accept a request
err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset, with reset sampled high at a posedge:
  - all outputs go to 0, including the held data registers;
  - state IDLE, starvation counter 0, watchdog counter 0, owner CH_NONE.
- Reset mid-operation abandons the request. A ddr_operation_done arriving later is ignored because the block is in IDLE.
- FSM has two states, IDLE and WAIT.
- IDLE, cycle T, with ddr_ready=1 and any valid high:
  - select one channel; assert its *_index_ready combinationally in cycle T (valid && ready = accept);
  - register index, mask and data; owner <= channel; state <= WAIT;
  - in cycle T+1 ddr_chip_enable=1 for exactly one cycle, with ddr_index, ddr_write_enable and ddr_burst_mode valid;
  - ddr_index, ddr_write_enable, ddr_burst_mode and the store mask/data stay stable throughout WAIT.
- IDLE with ddr_ready=0: no grant; all ready outputs are 0.
- Priority, normal: store > load > pc.
- Priority, forced: when starve_cnt == STARVE_LIMIT, pc > store > load.
- Starvation counter:
  - increments on each store/load grant while pc_index_valid=1, saturating at STARVE_LIMIT;
  - clears on a pc grant, or on any cycle with pc_index_valid=0.
- WAIT:
  - ddr_operation_done is accepted in any WAIT cycle, including T+1.
  - On done at cycle D, for owner pc: capture ddr_pc_read_inst into pc_read_inst.
  - On done at cycle D, for owner load: capture ddr_opload_read_data into opload_read_data.
  - At D+1 the owner's *_operation_done=1 for one cycle, and the block is back in IDLE.
  - The earliest next grant is in cycle D+1.
  - Done with owner = store updates no data register.
- Back-to-back: a new grant in D+1 places the next chip_enable at D+2. Throughput is one request per 2 + DDR-latency cycles.
- Watchdog:
  - wd_cnt counts WAIT cycles;
  - if it reaches TIMEOUT_CYCLES without done: err_timeout <= 1 (sticky until reset), the owner's done pulses with its data register unchanged, and the block returns to IDLE.
- Done with no owner (IDLE): ignored, no pulses.
- Requesters may drop valid after acceptance. A valid that is not accepted must hold its index and data stable.

Decomposition:
- Shared package ddr_arb_pkg:
  - DDR_INDEX_W=19, DDR_DATA_W=64, DDR_BURST_W=512;
  - state enum {ARB_IDLE, ARB_WAIT};
  - channel enum {CH_NONE, CH_STORE, CH_LOAD, CH_PC}.
- One sub-module, ddr_arb_prio_sel: a combinational picker. Inputs are the three valids and pc_force; outputs are a one-hot grant plus a channel enum.

Test Plan:
- Single load, index 19'h00010; DDR returns done 3 cycles after chip_enable with data 64'hDEAD_BEEF -> opload_index_ready at T, chip_enable at T+1 with write_enable=0 and burst=0, opload_operation_done one cycle after done, opload_read_data=64'hDEAD_BEEF and held.
- Store and load and pc all valid in the same cycle -> grant order store, load, pc. Store issues with write_enable=1 and mask/data passed through; pc issues with burst=1; pc_read_inst equals the 512-bit pattern.
- pc valid continuously, with load and store re-requesting every cycle, STARVE_LIMIT=4 -> pc granted after exactly 4 data grants; counter then clears.
- ddr_ready=0 for 5 cycles with load valid -> no ready, no chip_enable; grant in the first cycle ddr_ready=1.
- No done for TIMEOUT_CYCLES=16 -> err_timeout=1 at cycle 16 of WAIT, owner done pulses, IDLE; a later stray ddr_operation_done produces no pulse.
- Reset asserted in WAIT, then done arrives -> all outputs 0, no done pulse; next request served normally.
